// File: rtl/led_ring_stepper_if.sv
// Control/status bundle between the input decoder, the ring stepper and the LED driver.
// The stepper takes the slave modport; the decoder side takes master.
interface led_ring_stepper_if #(
  parameter int unsigned NPOS = 8,
  parameter int unsigned PW   = $clog2(NPOS),
  parameter int unsigned DIVW = 16,
  parameter int unsigned LAPW = 8
);
  localparam int unsigned COLS = NPOS / 2;

  logic            step_valid;
  logic            step_ready;
  logic            dir;
  logic            auto_en;
  logic [DIVW-1:0] div_val;
  logic            load;
  logic [PW-1:0]   load_pos;
  logic [PW-1:0]   pos;
  logic            wrap;
  logic [LAPW-1:0] lap;
  logic [COLS-1:0] led_top;
  logic [COLS-1:0] led_mid;
  logic [COLS-1:0] led_bot;

  modport master (
    output step_valid, dir, auto_en, div_val, load, load_pos,
    input  step_ready, pos, wrap, lap, led_top, led_mid, led_bot
  );

  modport slave (
    input  step_valid, dir, auto_en, div_val, load, load_pos,
    output step_ready, pos, wrap, lap, led_top, led_mid, led_bot
  );
endinterface

// File: rtl/led_ring_stepper.sv
// NPOS-position ring stepper with manual/auto stepping, load, wrap pulse and signed lap count.
// Position is decoded onto a 3-row x NPOS/2-column LED grid.
module led_ring_stepper #(
  parameter int unsigned NPOS = 8,
  parameter int unsigned PW   = $clog2(NPOS),
  parameter int unsigned DIVW = 16,
  parameter int unsigned LAPW = 8
) (
  input logic               clk,
  input logic               rst,
  led_ring_stepper_if.slave bus
);
  localparam int unsigned   COLS   = NPOS / 2;
  localparam logic [PW-1:0] PosMax = PW'(NPOS - 1);

  typedef enum logic {StManual, StAuto} state_e;

  state_e          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [LAPW-1:0] lap_q, lap_d;
  logic            wrap_q, wrap_d;

  logic [DIVW-1:0] period_m1;
  logic            tick;
  logic            step;
  logic [COLS-1:0] led_top, led_mid, led_bot;

  always_comb begin
    // A div_val of 0 behaves as 1; >= lets a shrunken period fire immediately.
    period_m1 = (bus.div_val == '0) ? '0 : bus.div_val - 1'b1;
    tick      = (div_q >= period_m1);
    step      = (state_q == StManual) ? bus.step_valid : tick;

    state_d = state_q;
    div_d   = div_q;
    pos_d   = pos_q;
    lap_d   = lap_q;
    wrap_d  = 1'b0;

    if (state_q == StAuto) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    case (state_q)
      StManual: begin
        if (bus.auto_en) begin
          state_d = StAuto;
          div_d   = '0;
        end
      end
      StAuto: begin
        if (!bus.auto_en) begin
          state_d = StManual;
          div_d   = '0;
        end
      end
      default: state_d = StManual;
    endcase

    if (bus.load) begin
      pos_d = (bus.load_pos > PosMax) ? PosMax : bus.load_pos;
      div_d = '0;
    end else if (step) begin
      if (bus.dir) begin
        if (pos_q == PosMax) begin
          pos_d  = '0;
          wrap_d = 1'b1;
          lap_d  = lap_q + 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = PosMax;
          wrap_d = 1'b1;
          lap_d  = lap_q - 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StManual;
      div_q   <= '0;
      pos_q   <= '0;
      lap_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pos_q   <= pos_d;
      lap_q   <= lap_d;
      wrap_q  <= wrap_d;
    end
  end

  // Left half of the ring lights top+mid from the left; right half lights mid+bot from the right.
  always_comb begin
    led_top = '0;
    led_mid = '0;
    led_bot = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (pos_q == PW'(c)) begin
        led_top[COLS-1-c] = 1'b1;
        led_mid[COLS-1-c] = 1'b1;
      end
      if (pos_q == PW'(c + COLS)) begin
        led_mid[c] = 1'b1;
        led_bot[c] = 1'b1;
      end
    end
  end

  assign bus.step_ready = (state_q == StManual);
  assign bus.pos        = pos_q;
  assign bus.wrap       = wrap_q;
  assign bus.lap        = lap_q;
  assign bus.led_top    = led_top;
  assign bus.led_mid    = led_mid;
  assign bus.led_bot    = led_bot;
endmodule

// File: tb/tb_led_ring_stepper.sv
// Directed bench: table of per-cycle vectors on an 8-position ring, then hand sequences
// on a 12-position ring for multi-lap wrap counting and load clamping.
module tb_led_ring_stepper;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst12;

  led_ring_stepper_if #(.NPOS(8))  b8 ();
  led_ring_stepper_if #(.NPOS(12)) b12 ();

  led_ring_stepper #(.NPOS(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (b8.slave)
  );

  led_ring_stepper #(.NPOS(12)) dut12 (
    .clk (clk),
    .rst (rst12),
    .bus (b12.slave)
  );

  typedef struct {
    logic        rst;
    logic        sv;
    logic        dir;
    logic        auto_en;
    logic [15:0] div;
    logic        load;
    logic [2:0]  lpos;
    logic [2:0]  pos;
    logic        wrap;
    logic [7:0]  lap;
    logic        ready;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // row: 0 = top, 1 = mid, 2 = bot
  function automatic logic [31:0] led_exp(input int npos, input int p, input int row);
    int cols = npos / 2;
    logic [31:0] one = 32'd1;
    if (p < cols) return (row == 2) ? 32'd0 : (one << (cols - 1 - p));
    return (row == 0) ? 32'd0 : (one << (p - cols));
  endfunction

  function automatic void add(input logic r, input logic sv, input logic d, input logic a,
                              input logic [15:0] dv, input logic l, input logic [2:0] lp,
                              input logic [2:0] p, input logic w, input logic [7:0] lap,
                              input logic rdy);
    vq.push_back('{r, sv, d, a, dv, l, lp, p, w, lap, rdy});
  endfunction

  initial begin
    int wraps;

    // reset and a full forward lap
    add(1, 0, 1, 0, 3, 0, 0, 0, 0, 8'h00, 1);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 1, 0, 3, 0, 0, 3'(k % 8), (k == 8), (k == 8) ? 8'h01 : 8'h00, 1);
    // backward wrap from 0, then forward wrap back
    add(1, 0, 1, 0, 3, 0, 0, 0, 0, 8'h00, 1);
    add(0, 1, 0, 0, 3, 0, 0, 7, 1, 8'hFF, 1);
    add(0, 0, 0, 0, 3, 0, 0, 7, 0, 8'hFF, 1);
    add(0, 1, 1, 0, 3, 0, 0, 0, 1, 8'h00, 1);
    // load beats step
    add(0, 1, 1, 0, 3, 1, 5, 5, 0, 8'h00, 1);
    add(0, 1, 0, 0, 3, 1, 7, 7, 0, 8'h00, 1);
    add(0, 1, 1, 0, 3, 0, 0, 0, 1, 8'h01, 1);
    // auto, period 3, step_valid ignored
    add(0, 0, 1, 1, 3, 0, 0, 0, 0, 8'h01, 0);
    add(0, 1, 1, 1, 3, 0, 0, 0, 0, 8'h01, 0);
    add(0, 1, 1, 1, 3, 0, 0, 0, 0, 8'h01, 0);
    add(0, 1, 1, 1, 3, 0, 0, 1, 0, 8'h01, 0);
    add(0, 1, 1, 1, 3, 0, 0, 1, 0, 8'h01, 0);
    add(0, 0, 1, 1, 3, 0, 0, 1, 0, 8'h01, 0);
    add(0, 0, 1, 1, 3, 0, 0, 2, 0, 8'h01, 0);
    // div_val 0 steps every cycle
    for (int k = 3; k <= 6; k++) add(0, 0, 1, 1, 0, 0, 0, 3'(k), 0, 8'h01, 0);
    // reset mid-auto
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, 8'h00, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1);
    // step coincident with switch to auto uses manual rules
    add(0, 1, 1, 1, 5, 0, 0, 1, 0, 8'h00, 0);
    add(0, 0, 1, 0, 5, 0, 0, 1, 0, 8'h00, 1);
    // shrinking period below the running divider fires next cycle
    add(0, 0, 1, 1, 5, 0, 0, 1, 0, 8'h00, 0);
    add(0, 0, 1, 1, 5, 0, 0, 1, 0, 8'h00, 0);
    add(0, 0, 1, 1, 5, 0, 0, 1, 0, 8'h00, 0);
    add(0, 0, 1, 1, 5, 0, 0, 1, 0, 8'h00, 0);
    add(0, 0, 1, 1, 2, 0, 0, 2, 0, 8'h00, 0);
    add(0, 0, 1, 1, 2, 0, 0, 2, 0, 8'h00, 0);
    add(0, 0, 1, 1, 2, 0, 0, 3, 0, 8'h00, 0);
    // reset beats load and step
    add(1, 1, 1, 1, 2, 1, 5, 0, 0, 8'h00, 1);

    rst12 = 1'b1;
    b12.step_valid = 1'b0;
    b12.dir = 1'b1;
    b12.auto_en = 1'b0;
    b12.div_val = 16'd1;
    b12.load = 1'b0;
    b12.load_pos = '0;

    foreach (vq[i]) begin
      rst8          = vq[i].rst;
      b8.step_valid = vq[i].sv;
      b8.dir        = vq[i].dir;
      b8.auto_en    = vq[i].auto_en;
      b8.div_val    = vq[i].div;
      b8.load       = vq[i].load;
      b8.load_pos   = vq[i].lpos;
      @(posedge clk);
      #1;
      chk("pos8", i, 32'(b8.pos), 32'(vq[i].pos));
      chk("wrap8", i, 32'(b8.wrap), 32'(vq[i].wrap));
      chk("lap8", i, 32'(b8.lap), 32'(vq[i].lap));
      chk("ready8", i, 32'(b8.step_ready), 32'(vq[i].ready));
      chk("top8", i, 32'(b8.led_top), led_exp(8, int'(vq[i].pos), 0));
      chk("mid8", i, 32'(b8.led_mid), led_exp(8, int'(vq[i].pos), 1));
      chk("bot8", i, 32'(b8.led_bot), led_exp(8, int'(vq[i].pos), 2));
    end
    rst8 = 1'b0;
    b8.step_valid = 1'b0;
    b8.auto_en = 1'b0;
    b8.load = 1'b0;

    // 12-position ring: two full forward laps
    @(posedge clk);
    #1;
    chk("pos12_rst", 0, 32'(b12.pos), 32'd0);
    rst12 = 1'b0;
    b12.step_valid = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk);
      #1;
      if (b12.wrap) wraps++;
      chk("pos12", k, 32'(b12.pos), 32'(k % 12));
      chk("wrap12", k, 32'(b12.wrap), 32'((k % 12) == 0));
      chk("bits12", k, 32'($countones({b12.led_top, b12.led_mid, b12.led_bot})), 32'd2);
      chk("mid12", k, 32'(b12.led_mid), led_exp(12, k % 12, 1));
    end
    chk("lap12", 24, 32'(b12.lap), 32'd2);
    chk("wraps12", 24, 32'(wraps), 32'd2);

    // out-of-range loads clamp to the last position
    b12.step_valid = 1'b0;
    b12.load = 1'b1;
    b12.load_pos = 4'd13;
    @(posedge clk);
    #1;
    chk("clamp13", 0, 32'(b12.pos), 32'd11);
    b12.load_pos = 4'd3;
    @(posedge clk);
    #1;
    chk("load3", 0, 32'(b12.pos), 32'd3);
    b12.load_pos = 4'd15;
    @(posedge clk);
    #1;
    chk("clamp15", 0, 32'(b12.pos), 32'd11);
    chk("lap12_load", 0, 32'(b12.lap), 32'd2);
    b12.load = 1'b0;
    b12.step_valid = 1'b1;
    b12.dir = 1'b0;
    @(posedge clk);
    #1;
    chk("back12", 0, 32'(b12.pos), 32'd10);
    chk("back12_wrap", 0, 32'(b12.wrap), 32'd0);
    chk("top12", 0, 32'(b12.led_top), led_exp(12, 10, 0));
    chk("bot12", 0, 32'(b12.led_bot), led_exp(12, 10, 2));
    b12.step_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
